// File: rtl/and4_gate_sequencer_tester.sv
// Exhaustive sweep tester for a dual 4-input AND gate: applies all 256 input
// vectors, waits a settle time, samples both outputs and tallies mismatches.
`timescale 1ns/1ps
module and4_gate_sequencer_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [1:0] dut_y_i,
  output logic [7:0] stim_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [8:0] err_count_o,
  output logic [7:0] first_fail_vec_o,
  output logic [1:0] first_fail_y_o,
  output logic       fail_valid_o
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       stim_q, stim_d;
  logic [1:0]       y_q, y_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [8:0]       err_q, err_d;
  logic [7:0]       ffv_q, ffv_d;
  logic [1:0]       ffy_q, ffy_d;
  logic             fv_q, fv_d;
  logic [1:0]       exp_y;

  // stim_q holds the vector under test throughout SETTLE and CHECK
  assign exp_y = {&stim_q[7:4], &stim_q[3:0]};

  // NOTE: every _d gets its default first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    y_d     = y_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffy_d   = ffy_q;
    fv_d    = fv_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d   = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        stim_d  = vec_q;
        cnt_d   = CNT_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_ONE) begin
          y_d     = dut_y_i;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CHECK: begin
        if (y_q != exp_y) begin
          err_d = err_q + 9'd1;
          if (!fv_q) begin
            ffv_d = stim_q;
            ffy_d = y_q;
            fv_d  = 1'b1;
          end
        end
        if (vec_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = APPLY;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 9'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides any transition while a sweep is running
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      stim_d  = '0;
      pass_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffy_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      y_q     <= y_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffy_q   <= ffy_d;
      fv_q    <= fv_d;
    end
  end

  assign stim_o           = stim_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_fail_vec_o = ffv_q;
  assign first_fail_y_o   = ffy_q;
  assign fail_valid_o     = fv_q;

endmodule
